// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I core: opcodes, FSM states,
// datapath mux selects and branch funct3 values.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_J_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'b00,
    A_PC   = 2'b01,
    A_ZERO = 2'b10
  } alu_a_sel_t;

  typedef enum logic [1:0] {
    B_RS2 = 2'b00,
    B_IMM = 2'b01
  } alu_b_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic is_legal_op(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_J_JAL, OP_JALR: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/br_cond.sv
// Branch condition evaluation from ALU compare flags; flags funct3 values
// that are not RV32I branches.
module br_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       taken,
  output logic       bad_f3
);

  always_comb begin
    taken  = 1'b0;
    bad_f3 = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_zero;
      F3_BNE:  taken = !alu_zero;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      F3_BLTU: taken = alu_ltu;
      F3_BGEU: taken = !alu_ltu;
      default: bad_f3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle RV32I core: fetch/decode/exec/mem/wb
// strobes, memory handshake with watchdog, branch resolution, retire counter.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t          cur, nxt;
  logic [TO_W-1:0] wd;
  logic            taken, bad_f3;
  logic            set_illegal, set_bus_err, retire;
  logic            in_wait, timeout;
  logic            is_store;
  alu_a_sel_t      op_a;
  alu_b_sel_t      op_b;

  br_cond u_br_cond (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .alu_ltu  (alu_ltu),
    .taken    (taken),
    .bad_f3   (bad_f3)
  );

  assign state    = cur;
  assign is_store = (opcode == OP_STORE);
  assign in_wait  = ((cur == ST_FETCH) || (cur == ST_MEM)) && !mem_ready;
  // A ready arriving on the limit cycle completes normally; only a miss traps.
  assign timeout  = in_wait && (wd == WD_LIMIT);

  // Operand selects are driven through EXEC, MEM and WB so the ALU result
  // stays valid for the memory address and the JALR/AUIPC/LUI writeback.
  always_comb begin
    op_a = A_RS1;
    op_b = B_RS2;
    case (opcode)
      OP_I, OP_LOAD, OP_STORE, OP_JALR: op_b = B_IMM;
      OP_AUIPC: begin
        op_a = A_PC;
        op_b = B_IMM;
      end
      OP_LUI: begin
        op_a = A_ZERO;
        op_b = B_IMM;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt          = cur;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_a_sel    = A_RS1;
    alu_b_sel    = B_RS2;
    wb_sel       = WB_ALU;
    set_illegal  = 1'b0;
    set_bus_err  = 1'b0;
    retire       = 1'b0;
    case (cur)
      ST_BOOT: nxt = ST_FETCH;
      ST_FETCH: begin
        if (timeout) begin
          set_bus_err = 1'b1;
          nxt         = ST_TRAP;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            nxt   = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        if (is_legal_op(opcode)) begin
          nxt = ST_EXEC;
        end else begin
          set_illegal = 1'b1;
          nxt         = ST_TRAP;
        end
      end
      ST_EXEC: begin
        alu_a_sel = op_a;
        alu_b_sel = op_b;
        case (opcode)
          OP_LOAD, OP_STORE: nxt = ST_MEM;
          OP_BRANCH: begin
            if (bad_f3) begin
              set_illegal = 1'b1;
              nxt         = ST_TRAP;
            end else begin
              pc_we  = 1'b1;
              pc_sel = taken ? PC_IMM : PC_PLUS4;
              retire = 1'b1;
              nxt    = ST_FETCH;
            end
          end
          default: nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        alu_a_sel    = op_a;
        alu_b_sel    = op_b;
        mem_addr_sel = 1'b1;
        if (timeout) begin
          set_bus_err = 1'b1;
          nxt         = ST_TRAP;
        end else begin
          mem_req = 1'b1;
          mem_we  = is_store;
          if (mem_ready) begin
            if (is_store) begin
              pc_we  = 1'b1;
              retire = 1'b1;
              nxt    = ST_FETCH;
            end else begin
              nxt = ST_WB;
            end
          end
        end
      end
      ST_WB: begin
        alu_a_sel = op_a;
        alu_b_sel = op_b;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        nxt       = ST_FETCH;
        case (opcode)
          OP_LOAD:  wb_sel = WB_MEM;
          OP_J_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          OP_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_ALU;
          end
          default: ;
        endcase
      end
      ST_TRAP: nxt = ST_TRAP;
      default: nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= ST_BOOT;
      wd      <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)   wd <= '0;
      else if (in_wait) wd <= wd + TO_W'(1);
      else              wd <= '0;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (retire)      instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push expected
// strobe events; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alu_zero, alu_lt, alu_ltu, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, rf_we, pc_we;
  logic [1:0]  pc_sel, alu_a_sel, alu_b_sel, wb_sel;
  logic [2:0]  state;
  logic        illegal, bus_err;
  logic [31:0] instret;

  multicycle_ctrl #(.TO_W(8), .MEM_TIMEOUT(200), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .wb_sel(wb_sel), .state(state), .illegal(illegal), .bus_err(bus_err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        ir, rf, pc;
    logic [1:0]  pcs, wbs, as, bs;
    logic        mreq, mwe, maddr;
    logic [31:0] cnt;
  } exp_t;

  exp_t       expq[$];
  logic [2:0] trace[$];
  int         vecs = 0;
  int         errs = 0;

  function automatic exp_t ev(logic [2:0] st, logic ir, logic rf, logic pc,
                              logic [1:0] pcs, logic [1:0] wbs, logic [1:0] as,
                              logic [1:0] bs, logic mreq, logic mwe,
                              logic maddr, int unsigned cnt);
    exp_t e;
    e = '{st, ir, rf, pc, pcs, wbs, as, bs, mreq, mwe, maddr, cnt};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe cycle, plus every MEM cycle with a pending request.
  initial begin
    exp_t act, e;
    forever begin
      @(negedge clk);
      if (!rst && (ir_we || rf_we || pc_we || (mem_req && state == 3'd4))) begin
        act = '{state, ir_we, rf_we, pc_we, pc_sel, wb_sel, alu_a_sel, alu_b_sel,
                mem_req, mem_we, mem_addr_sel, instret};
        vecs++;
        if (expq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_event: got %h expected none", act);
        end else begin
          e = expq.pop_front();
          if (act !== e) begin
            errs++;
            $display("FAIL event: got %h expected %h", act, e);
          end
        end
      end
    end
  end

  // Starts in FETCH at posedge+1; responds to the FETCH request at once and
  // stalls MEM for mw cycles; returns on the next FETCH or TRAP.
  task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic lt, input logic ltu,
                     input int mw, input int lat);
    int cyc = 0;
    int w   = 0;
    opcode = op; funct3 = f3; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
    trace.delete();
    do begin
      if (state == 3'd1) mem_ready = 1'b1;
      else if (state == 3'd4) begin
        mem_ready = (w == mw);
        w++;
      end else mem_ready = 1'b0;
      tick();
      cyc++;
      trace.push_back(state);
    end while (state != 3'd1 && state != 3'd6 && cyc < 40);
    mem_ready = 1'b0;
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad, cyc;
    rst = 1'b1; opcode = '0; funct3 = '0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b0;
    repeat (3) tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_outs", 64'({mem_req, mem_we, mem_addr_sel, ir_we, rf_we, pc_we, pc_sel,
                         alu_a_sel, alu_b_sel, wb_sel, illegal, bus_err}), 64'd0);
    rst = 1'b0;
    chk("boot_state", 64'(state), 64'd0);
    tick();
    chk("boot_to_fetch", 64'(state), 64'd1);

    // Store aborted by reset while waiting in MEM
    opcode = 7'b0100011;
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0));
    expq.push_back(ev(3'd4, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 1, 1, 1, 0));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    chk("store_in_mem", 64'(state), 64'd4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", 64'({mem_req, mem_we, pc_we}), 64'd0);
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_instret", 64'(instret), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("abort_refetch", 64'(state), 64'd1);

    // ADD, zero-wait memory, with state trace
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0));
    expq.push_back(ev(3'd5, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    run("add", 7'b0110011, 3'b000, 0, 0, 0, 0, 4);
    n = 0;
    foreach (trace[i]) n = (n << 3) | int'(trace[i]);
    chk("add_trace", 64'(n), 64'(12'o2351));
    chk("add_instret", 64'(instret), 64'd1);

    // LW with three MEM wait cycles
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1));
    repeat (4) expq.push_back(ev(3'd4, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 1, 1));
    expq.push_back(ev(3'd5, 0, 1, 1, 2'b00, 2'b01, 2'b00, 2'b01, 0, 0, 0, 1));
    run("lw", 7'b0000011, 3'b010, 0, 0, 0, 3, 8);

    // SW zero-wait
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2));
    expq.push_back(ev(3'd4, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1, 1, 1, 2));
    run("sw", 7'b0100011, 3'b010, 0, 0, 0, 0, 4);

    // Branches: BNE taken / not taken, BLT taken, BGEU not taken, BEQ taken
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 3));
    expq.push_back(ev(3'd3, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 3));
    run("bne_t", 7'b1100011, 3'b001, 0, 0, 0, 0, 3);
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 4));
    expq.push_back(ev(3'd3, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 4));
    run("bne_nt", 7'b1100011, 3'b001, 1, 0, 0, 0, 3);
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 5));
    expq.push_back(ev(3'd3, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5));
    run("blt_t", 7'b1100011, 3'b100, 0, 1, 0, 0, 3);
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 6));
    expq.push_back(ev(3'd3, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 6));
    run("bgeu_nt", 7'b1100011, 3'b111, 0, 0, 1, 0, 3);
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 7));
    expq.push_back(ev(3'd3, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 7));
    run("beq_t", 7'b1100011, 3'b000, 1, 0, 0, 0, 3);

    // Jumps and upper-immediate forms
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 8));
    expq.push_back(ev(3'd5, 0, 1, 1, 2'b10, 2'b10, 2'b00, 2'b01, 0, 0, 0, 8));
    run("jalr", 7'b1100111, 3'b000, 0, 0, 0, 0, 4);
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 9));
    expq.push_back(ev(3'd5, 0, 1, 1, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 9));
    run("jal", 7'b1101111, 3'b000, 0, 0, 0, 0, 4);
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 10));
    expq.push_back(ev(3'd5, 0, 1, 1, 2'b00, 2'b00, 2'b10, 2'b01, 0, 0, 0, 10));
    run("lui", 7'b0110111, 3'b000, 0, 0, 0, 0, 4);
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 11));
    expq.push_back(ev(3'd5, 0, 1, 1, 2'b00, 2'b00, 2'b01, 2'b01, 0, 0, 0, 11));
    run("auipc", 7'b0010111, 3'b000, 0, 0, 0, 0, 4);
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 12));
    expq.push_back(ev(3'd5, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 12));
    run("addi", 7'b0010011, 3'b000, 0, 0, 0, 0, 4);
    chk("instret_13", 64'(instret), 64'd13);

    // Ready on exactly the limit cycle: completion wins over the watchdog
    repeat (200) tick();
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 13));
    expq.push_back(ev(3'd5, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 13));
    run("edge_add", 7'b0110011, 3'b000, 0, 0, 0, 0, 4);
    chk("edge_bus_err", 64'(bus_err), 64'd0);
    chk("instret_14", 64'(instret), 64'd14);

    // Illegal opcode: trap after DECODE, quiet for 20 cycles
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 14));
    run("ill_op", 7'b1111111, 3'b000, 0, 0, 0, 0, 2);
    chk("ill_op_flag", 64'({illegal, bus_err}), 64'b10);
    bad = 0;
    repeat (20) begin
      tick();
      if (state != 3'd6 || {mem_req, mem_we, ir_we, rf_we, pc_we} != 5'b0) bad++;
    end
    chk("trap_quiet", 64'(bad), 64'd0);
    do_reset();
    chk("illegal_cleared", 64'({illegal, state}), 64'({1'b0, 3'd1}));

    // Reserved branch funct3
    expq.push_back(ev(3'd1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0));
    run("ill_f3", 7'b1100011, 3'b010, 0, 0, 0, 0, 3);
    chk("ill_f3_flag", 64'({illegal, bus_err, state}), 64'({2'b10, 3'd6}));
    chk("ill_f3_instret", 64'(instret), 64'd0);
    do_reset();

    // Fetch watchdog: no ready ever
    mem_ready = 1'b0;
    n = 0;
    cyc = 0;
    while (state != 3'd6 && cyc < 400) begin
      if (state == 3'd1 && mem_req) n++;
      tick();
      cyc++;
    end
    chk("wd_req_cycles", 64'(n), 64'd200);
    chk("wd_trap", 64'({bus_err, illegal, state}), 64'({2'b10, 3'd6}));

    repeat (2) tick();
    chk("sb_drain", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main sequencing FSM for the multi-cycle RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the enables and mux selects for the PC, IR, register file, ALU operand muxes and the shared memory port, and it handshakes with memory over req/ready. The ALU operation itself comes from the separate ALU decoder; this block only sequences the datapath and decides branch outcomes from ALU flags.

Parameters:
TO_W, 8, width of the memory-wait watchdog counter
MEM_TIMEOUT, 200, max cycles mem_req may stay high without mem_ready before a bus-error trap (must be < 2^TO_W)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
opcode  in  7  IR[6:0], valid from DECODE onward
funct3  in  3  IR[14:12]
alu_zero  in  1  ALU result == 0
alu_lt  in  1  signed rs1 < rs2
alu_ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until the mem_ready cycle inclusive
mem_we  out  1  store qualifier, valid with mem_req
mem_addr_sel  out  1  0=PC (fetch), 1=ALU result (load/store)
ir_we  out  1  IR load pulse
rf_we  out  1  register-file write pulse
pc_we  out  1  PC update pulse
pc_sel  out  2  00=pc+4, 01=pc+imm adder, 10=ALU result & ~1 (JALR)
alu_a_sel  out  2  00=rs1, 01=PC, 10=zero
alu_b_sel  out  2  00=rs2, 01=imm
wb_sel  out  2  00=ALU, 01=mem rdata, 10=pc+4
state  out  3  current state, for debug
illegal  out  1  sticky, set on illegal opcode or branch funct3
bus_err  out  1  sticky, set on memory timeout
instret  out  CNT_W  retired-instruction count

Behaviour:
- States: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset: state=BOOT, instret=0, illegal=0, bus_err=0, watchdog=0, and all outputs 0. BOOT always goes to FETCH on the next cycle.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. On mem_ready: ir_we=1 in that same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: no strobes; register file is read.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111. These go to EXEC.
  - Any other opcode: set illegal and go to TRAP.
- EXEC, per opcode:
  - R-type: alu_a_sel=00, alu_b_sel=00.
  - I-type, load, store, JALR: alu_a_sel=00, alu_b_sel=01.
  - AUIPC: alu_a_sel=01, alu_b_sel=01.
  - LUI: alu_a_sel=10, alu_b_sel=01.
  - Load/store go to MEM. Branch goes to FETCH. All others go to WB.
- Branch, evaluated in EXEC by funct3:
  - 000 taken=alu_zero; 001 taken=!alu_zero.
  - 100 taken=alu_lt; 101 taken=!alu_lt.
  - 110 taken=alu_ltu; 111 taken=!alu_ltu.
  - 010/011: set illegal, go to TRAP, no pc_we.
  - Otherwise pc_we=1 and pc_sel=taken?01:00. instret increments in this cycle.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for stores only; ALU selects are held from EXEC. On mem_ready:
  - Load: go to WB.
  - Store: pc_we=1, pc_sel=00, instret++, go to FETCH.
- WB: rf_we=1 and pc_we=1, then go to FETCH; instret++.
  - wb_sel: load 01; JAL/JALR 10; all others 00.
  - pc_sel: JAL 01; JALR 10; all others 00.
- TRAP: absorbing, all strobes 0. Only rst leaves it.
- Watchdog: counts cycles in FETCH/MEM while mem_ready=0, and clears on state change. When the count reaches MEM_TIMEOUT: set bus_err, drop mem_req, go to TRAP.
  - If mem_ready arrives in the same cycle the count reaches MEM_TIMEOUT, the completion wins.
- Minimum latency with zero-wait memory: ALU/jump/LUI/AUIPC 4 cycles; load 5; store 4; branch 3. Each added memory wait cycle adds 1.
- instret wraps modulo 2^CNT_W. Exactly one increment per retired instruction.
- rst asserted mid-instruction returns to BOOT immediately. No partial write is issued after reset.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants (OP_R … OP_J_JAL);
  - state encodings;
  - pc_sel, alu_a_sel, alu_b_sel and wb_sel encodings;
  - branch funct3 constants.
- Sub-module br_cond: combinational, takes funct3 and the three flags, returns taken and bad_f3. It is reusable by a later pipelined core.

Test Plan:
- ADD (opcode 0110011), mem_ready tied 1, from reset release → state 0,1,2,3,5,1. ir_we at FETCH, rf_we and pc_we with wb_sel=00, pc_sel=00 at WB; instret 0→1.
- LW (0000011) with mem_ready delayed 3 cycles in MEM → mem_req high 4 cycles with mem_addr_sel=1, mem_we=0. WB has wb_sel=01; load latency 8 cycles.
- BNE (1100011, f3=001): alu_zero=0 → pc_we with pc_sel=01 in EXEC. Repeat with alu_zero=1 → pc_sel=00. instret +1 each time, no rf_we.
- JALR (1100111) → WB asserts rf_we with wb_sel=10 and pc_we with pc_sel=10.
- Opcode 1111111 → TRAP after DECODE, illegal=1, all strobes 0 for 20 cycles. Same outcome for a branch with f3=010.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=200 → bus_err=1 and state TRAP after 200 wait cycles. Apply rst mid-MEM on a store → mem_we drops immediately, BOOT then FETCH, instret unchanged.
